bus_arbiter_mc: RTL and testbench
=================================

Name: bus_arbiter_mc

Overview:
- Parametrised multi-target request arbiter between NUM_REQ edge PEs and NUM_TGT memory controllers (type 0 = neighbour-info, type 1 = FV-info, further types reserved for output SRAM etc.).
- Each target has an independent round-robin arbiter, so up to NUM_TGT requests can be accepted per cycle.
- Each target output is a registered valid/ready slot with backpressure. A winning request is forwarded with its PE tag (requester index).
- Requests with an out-of-range type are acknowledged, dropped and counted.

Parameters:
- NUM_REQ, 4: number of requesting PEs (>=2).
- NUM_TGT, 2: number of target controllers (>=1).
- TYPE_W, 2: request type field width; 2**TYPE_W >= NUM_TGT.
- NODE_W, 10: node id width.
- TAG_W, 2: PE tag width; 2**TAG_W >= NUM_REQ.
- ERR_W, 8: drop counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-PE request valid.
- req_type  in  NUM_REQ*TYPE_W  per-PE target select; slice i = [i*TYPE_W +: TYPE_W].
- req_node_id  in  NUM_REQ*NODE_W  per-PE node id.
- req_ready  out  NUM_REQ  per-PE grant/accept.
- tgt_valid  out  NUM_TGT  output slot valid per target.
- tgt_node_id  out  NUM_TGT*NODE_W  forwarded node id.
- tgt_tag  out  NUM_TGT*TAG_W  index of the originating PE.
- tgt_ready  in  NUM_TGT  target accepts its slot this cycle.
- drop_cnt  out  ERR_W  saturating count of dropped bad-type requests.

Behaviour:
- Reset (async assert, sync release inside clk domain): tgt_valid=0, tgt_node_id=0, tgt_tag=0, drop_cnt=0, all RR pointers=0. req_ready is combinational and therefore 0 while tgt slots are empty of requests, i.e. req_ready=0 whenever req_valid=0.
- Requester handshake:
  - Transfer occurs at a rising edge when req_valid[i] & req_ready[i].
  - The PE holds req_valid, req_type and req_node_id stable until the transfer.
  - req_ready is combinational from req_* and internal state, with no dependency path from req_ready back into itself.
- Per-target t candidates: PEs with req_valid=1 and req_type==t.
- Slot t can load when tgt_valid[t]==0 or tgt_ready[t]==1 (pass-through refill, no bubble).
- If slot t can load and candidates exist:
  - The winner is the first candidate at or after ptr[t], searching upward with wrap modulo NUM_REQ.
  - req_ready[winner]=1 and all other candidates of t see 0.
  - At the edge: slot t loads node_id and tag=winner, tgt_valid[t]=1, ptr[t]=(winner+1) mod NUM_REQ.
- If slot t cannot load: no grant for t, ptr[t] unchanged, and the slot contents are held stable while tgt_valid=1 and tgt_ready=0.
- If the slot drains (tgt_valid & tgt_ready) with no new winner: tgt_valid[t]=0 next cycle.
- tgt_ready while tgt_valid=0 is ignored.
- Latency: request accepted at edge N appears on tgt_* from edge N; minimum accept-to-consume is 1 cycle.
- Different targets never interact: simultaneous grants to different PEs on different targets in the same cycle are normal.
- A PE receives at most one grant per cycle, because its type selects exactly one target.
- Bad type (req_type >= NUM_TGT):
  - req_ready=1 immediately with no arbitration and no slot written.
  - drop_cnt increments by the number of such transfers that cycle and saturates at 2**ERR_W-1.
- Pointer wrap: a winner of NUM_REQ-1 sets ptr=0.
- Fairness: with all PEs continuously requesting target t and tgt_ready=1, PEs are served in order 0,1,...,NUM_REQ-1,0,...
- Reset mid-operation clears slots and pointers immediately. Any in-flight slot contents are lost, and the PE must re-request.

Test Plan:
- Single request: NUM_REQ=4. PE2 req_type=1, node=0x055, tgt_ready=1 → req_ready=4'b0100 for one cycle; next cycle tgt_valid=2'b10, tgt_node_id[1]=0x055, tgt_tag[1]=2. Cycle after (no request) tgt_valid=0.
- Round-robin fairness: all 4 PEs held on type 0, tgt_ready[0]=1 → grants 0,1,2,3,0 on consecutive cycles; tgt_tag[0] sequence 0,1,2,3,0; ptr wraps.
- Backpressure: slot 0 valid with tag 1, tgt_ready[0]=0 for 3 cycles while PE3 requests type 0 → req_ready[3]=0 and tgt_* stable throughout. tgt_ready[0]=1 → same cycle req_ready[3]=1 and next cycle tag=3 with no bubble.
- Parallel targets: PE0 type 0 and PE1 type 1 simultaneously, both readies=1 → req_ready=4'b0011 in one cycle; both slots valid next cycle with tags 0 and 1.
- Bad type and saturation: ERR_W=2, PE0 req_type=3 with NUM_TGT=2 held 5 cycles → req_ready[0]=1 each cycle, no tgt_valid, drop_cnt=1,2,3,3,3.
- Async reset: assert reset mid-cycle with slots valid → tgt_valid=0 and drop_cnt=0 before the next edge. After release, PE1 alone on type 0 is granted first (ptr=0 search).

Source files
------------

// File: rtl/bus_arbiter_mc.sv
// Multi-target request arbiter: NUM_REQ PEs share NUM_TGT controllers.
// Each target has its own round-robin arbiter and a registered
// valid/ready output slot. Requests whose type names no target are
// acknowledged at once, dropped, and counted in a saturating counter.
module bus_arbiter_mc #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_TGT = 2,
  parameter int unsigned TYPE_W  = 2,
  parameter int unsigned NODE_W  = 10,
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TYPE_W-1:0]   req_type,
  input  logic [NUM_REQ*NODE_W-1:0]   req_node_id,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_TGT-1:0]          tgt_valid,
  output logic [NUM_TGT*NODE_W-1:0]   tgt_node_id,
  output logic [NUM_TGT*TAG_W-1:0]    tgt_tag,
  input  logic [NUM_TGT-1:0]          tgt_ready,
  output logic [ERR_W-1:0]            drop_cnt
);

  localparam int unsigned DROP_MAX = (32'd1 << ERR_W) - 32'd1;

  logic [NUM_TGT-1:0] can_load;
  logic [NUM_TGT-1:0] win_found;
  logic [TAG_W-1:0]   win_idx [NUM_TGT];
  logic [TAG_W-1:0]   ptr     [NUM_TGT];
  logic [NUM_REQ-1:0] bad;
  logic [ERR_W-1:0]   drop_next;

  // Per-target round-robin search from ptr, plus immediate accept of bad types.
  // req_ready depends only on req_*, slot state and pointers, never on itself.
  always_comb begin
    int unsigned idx;
    can_load  = '0;
    win_found = '0;
    req_ready = '0;
    bad       = '0;
    idx       = 0;
    for (int unsigned t = 0; t < NUM_TGT; t++) begin
      win_idx[t] = '0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (32'(req_type[i*TYPE_W +: TYPE_W]) >= NUM_TGT)) begin
        bad[i]       = 1'b1;
        req_ready[i] = 1'b1;
      end
    end
    for (int unsigned t = 0; t < NUM_TGT; t++) begin
      can_load[t] = !tgt_valid[t] || tgt_ready[t];
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(ptr[t]) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (can_load[t] && !win_found[t] && req_valid[idx] &&
            (32'(req_type[idx*TYPE_W +: TYPE_W]) == t)) begin
          win_found[t]   = 1'b1;
          win_idx[t]     = TAG_W'(idx);
          req_ready[idx] = 1'b1;
        end
      end
    end
  end

  // Next drop count: add this cycle's bad-type transfers, saturating.
  always_comb begin
    int unsigned nbad;
    int unsigned sum;
    nbad = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bad[i]) begin
        nbad = nbad + 1;
      end
    end
    sum       = 32'(drop_cnt) + nbad;
    drop_next = (sum > DROP_MAX) ? ERR_W'(DROP_MAX) : ERR_W'(sum);
  end

  // Output slots, pointers and drop counter; slot refills in the same cycle it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_valid   <= '0;
      tgt_node_id <= '0;
      tgt_tag     <= '0;
      drop_cnt    <= '0;
      for (int unsigned t = 0; t < NUM_TGT; t++) begin
        ptr[t] <= '0;
      end
    end else begin
      drop_cnt <= drop_next;
      for (int unsigned t = 0; t < NUM_TGT; t++) begin
        if (win_found[t]) begin
          tgt_valid[t]                   <= 1'b1;
          tgt_node_id[t*NODE_W +: NODE_W] <= req_node_id[32'(win_idx[t])*NODE_W +: NODE_W];
          tgt_tag[t*TAG_W +: TAG_W]       <= win_idx[t];
          ptr[t] <= (32'(win_idx[t]) == NUM_REQ - 1) ? '0 : win_idx[t] + 1'b1;
        end else if (tgt_ready[t]) begin
          tgt_valid[t] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mc.sv
// Bench for bus_arbiter_mc: directed scenarios followed by randomized
// traffic, all checked against a cycle-level reference model.
module tb_bus_arbiter_mc;

  localparam int NR = 4;
  localparam int NT = 2;
  localparam int TW = 2;
  localparam int NW = 10;
  localparam int GW = 2;
  localparam int EW = 2;
  localparam int DMAX = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*TW-1:0]  req_type;
  logic [NR*NW-1:0]  req_node_id;
  logic [NR-1:0]     req_ready;
  logic [NT-1:0]     tgt_valid;
  logic [NT*NW-1:0]  tgt_node_id;
  logic [NT*GW-1:0]  tgt_tag;
  logic [NT-1:0]     tgt_ready;
  logic [EW-1:0]     drop_cnt;

  bus_arbiter_mc #(
    .NUM_REQ(NR), .NUM_TGT(NT), .TYPE_W(TW), .NODE_W(NW), .TAG_W(GW), .ERR_W(EW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_type(req_type), .req_node_id(req_node_id),
    .req_ready(req_ready),
    .tgt_valid(tgt_valid), .tgt_node_id(tgt_node_id), .tgt_tag(tgt_tag),
    .tgt_ready(tgt_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_valid [NT];
  int            m_node  [NT];
  int            m_tag   [NT];
  int            m_ptr   [NT];
  int            m_drop;
  logic [NR-1:0] e_rdy;
  bit            e_found [NT];
  int            e_win   [NT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int ty, input int node);
    req_valid[i]          = v;
    req_type[i*TW +: TW]  = TW'(ty);
    req_node_id[i*NW +: NW] = NW'(node);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 0, 0);
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_valid[t] = 0; m_node[t] = 0; m_tag[t] = 0; m_ptr[t] = 0;
    end
    m_drop = 0;
  endtask

  function automatic int type_of(input int i);
    return int'(req_type[i*TW +: TW]);
  endfunction

  task automatic predict();
    e_rdy = '0;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && type_of(i) >= NT) e_rdy[i] = 1'b1;
    for (int t = 0; t < NT; t++) begin
      e_found[t] = 0;
      e_win[t]   = 0;
      if (!m_valid[t] || tgt_ready[t]) begin
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (m_ptr[t] + k) % NR;
          if (!e_found[t] && req_valid[i] && type_of(i) == t) begin
            e_found[t] = 1; e_win[t] = i; e_rdy[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic update();
    int nbad;
    nbad = 0;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && type_of(i) >= NT) nbad++;
    for (int t = 0; t < NT; t++) begin
      if (e_found[t]) begin
        m_valid[t] = 1;
        m_node[t]  = int'(req_node_id[e_win[t]*NW +: NW]);
        m_tag[t]   = e_win[t];
        m_ptr[t]   = (e_win[t] + 1) % NR;
      end else if (tgt_ready[t]) begin
        m_valid[t] = 0;
      end
    end
    m_drop = (m_drop + nbad > DMAX) ? DMAX : m_drop + nbad;
  endtask

  task automatic check_outputs();
    logic [NT-1:0] mv;
    for (int t = 0; t < NT; t++) mv[t] = m_valid[t];
    chk("tgt_valid", 32'(tgt_valid), 32'(mv));
    for (int t = 0; t < NT; t++) begin
      if (m_valid[t]) begin
        chk($sformatf("tgt_node%0d", t), 32'(tgt_node_id[t*NW +: NW]), 32'(m_node[t]));
        chk($sformatf("tgt_tag%0d", t), 32'(tgt_tag[t*GW +: GW]), 32'(m_tag[t]));
      end
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  task automatic step();
    #2;
    predict();
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    @(posedge clk);
    update();
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_type = '0; req_node_id = '0; tgt_ready = '0;
    model_reset();
    #1;
    chk("rst_valid", 32'(tgt_valid), 32'd0);
    chk("rst_node", 32'(tgt_node_id), 32'd0);
    chk("rst_tag", 32'(tgt_tag), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single request on target 1
    tgt_ready = 2'b11;
    set_req(2, 1'b1, 1, 'h055);
    step();
    chk("single_ready", 32'(e_rdy), 32'h4);
    chk("single_valid", 32'(tgt_valid), 32'h2);
    chk("single_node", 32'(tgt_node_id[NW +: NW]), 32'h055);
    chk("single_tag", 32'(tgt_tag[GW +: GW]), 32'd2);
    clear_reqs();
    step();
    chk("single_drain", 32'(tgt_valid), 32'h0);

    // round-robin fairness on target 0 with wrap
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 0, 'h100 + i);
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr_tag%0d", n), 32'(tgt_tag[0 +: GW]), 32'(n % NR));
    end
    clear_reqs();
    step();

    // backpressure: slot 0 holds tag 1 while PE3 waits
    set_req(1, 1'b1, 0, 'h2a1);
    step();
    clear_reqs();
    tgt_ready = 2'b10;
    set_req(3, 1'b1, 0, 'h3c3);
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("bp_hold%0d", n), 32'(req_ready[3]), 32'd0);
      chk($sformatf("bp_tag%0d", n), 32'(tgt_tag[0 +: GW]), 32'd1);
      chk($sformatf("bp_node%0d", n), 32'(tgt_node_id[0 +: NW]), 32'h2a1);
    end
    tgt_ready = 2'b11;
    step();
    chk("bp_release_rdy", 32'(e_rdy[3]), 32'd1);
    chk("bp_release_tag", 32'(tgt_tag[0 +: GW]), 32'd3);
    chk("bp_release_valid", 32'(tgt_valid[0]), 32'd1);
    clear_reqs();
    step();

    // parallel targets
    set_req(0, 1'b1, 0, 'h011);
    set_req(1, 1'b1, 1, 'h022);
    step();
    chk("par_ready", 32'(e_rdy), 32'h3);
    chk("par_valid", 32'(tgt_valid), 32'h3);
    clear_reqs();
    step();

    // bad type with saturation at 3
    set_req(0, 1'b1, 3, 'h3ff);
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("bad_rdy%0d", n), 32'(req_ready[0]), 32'd1);
      chk($sformatf("bad_cnt%0d", n), 32'(drop_cnt), 32'((n + 1 > 3) ? 3 : n + 1));
      chk($sformatf("bad_novalid%0d", n), 32'(tgt_valid), 32'd0);
    end
    clear_reqs();

    // async reset: leave ptr[0]=2 and both slots busy, then reset mid-cycle
    set_req(1, 1'b1, 0, 'h0f1);
    set_req(3, 1'b1, 1, 'h0f3);
    tgt_ready = 2'b00;
    step();
    clear_reqs();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(tgt_valid), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_tag", 32'(tgt_tag), 32'd0);
    model_reset();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // PE1 and PE3 both on target 0: a cleared pointer must pick PE1
    tgt_ready = 2'b11;
    set_req(1, 1'b1, 0, 'h111);
    set_req(3, 1'b1, 0, 'h333);
    step();
    chk("arst_first_tag", 32'(tgt_tag[0 +: GW]), 32'd1);
    clear_reqs();
    step();

    // randomized traffic; PEs hold requests until transferred
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
      tgt_ready = NT'($urandom_range(0, 3));
      step();
      for (int i = 0; i < NR; i++)
        if (e_rdy[i]) req_valid[i] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
